port_rr_arbiter: RTL and testbench
==================================

PORT_RR_ARBITER -- requirements
Module: port_rr_arbiter

Interface
REQ-001 Parameter: none; word width fixed at 11 bits signed, port count fixed at 4.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rready  input  4  per-port "word offered" flags; bit0 L, bit1 R, bit2 U, bit3 D.
REQ-005 din_l, din_r, din_u, din_d  input  11 each  signed words offered on each port.
REQ-006 mode  input  1  0 = round-robin, 1 = fixed priority L>R>U>D.
REQ-007 sink_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-008 read  output  4  one-hot, one-cycle pulse acknowledging the granted port.
REQ-009 out_valid  output  1  holding register contains a word.
REQ-010 out_data  output  11  signed word in holding register.
REQ-011 out_src  output  4  one-hot source port of out_data; 0 when empty.
REQ-012 grant_cnt  output  8  wrapping count of words accepted since reset.

Function
REQ-013 Single-entry holding register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 Consume occurs in a cycle where out_valid=1 and sink_ready=1.
REQ-015 Accept is permitted in a cycle when state is EMPTY, or FULL with consume in the same cycle.
REQ-016 Eligible ports: rready bits AND NOT cooldown mask.
REQ-017 Cooldown mask = port granted in previous cycle; masked for exactly one cycle, as requester rready lags read by one cycle.
REQ-018 On accept with at least one eligible port, arbiter picks one port g, sets read[g]=1 next cycle, loads out_data=din_g, out_src=onehot(g), out_valid=1.
REQ-019 read is registered; pulse appears in cycle after the accept edge and lasts one cycle; read is 0 in all other cycles.
REQ-020 Round-robin: search order starts at port after last_grant (L->R->U->D->L); last_grant updates only on accept.
REQ-021 Fixed mode: lowest-index eligible port wins; last_grant still updated.
REQ-022 Mode change takes effect on next arbitration; no state flush.
REQ-023 Consume without accept: out_valid=0, out_src=0, out_data holds last value.
REQ-024 Consume and accept same cycle: new word replaces old, out_valid stays 1; sustained throughput 1 word/cycle from alternating ports, 1 word/2 cycles from a single port.
REQ-025 FULL without consume: no read pulse, rready ignored, register unchanged.
REQ-026 No eligible port: no read pulse, last_grant unchanged.
REQ-027 grant_cnt increments by 1 on each accept, wraps 255->0.
REQ-028 Data passes unmodified; no sign or width conversion.

Reset
REQ-029 On rst: out_valid=0, out_data=0, out_src=0, read=0, grant_cnt=0, cooldown=0, last_grant=D (so first round-robin pick favours L).
REQ-030 rst asserted mid-transfer discards held word; pending read pulse is cancelled.
REQ-031 First accept possible on first clk edge after rst deasserts.

Structure
REQ-032 Shared package tis_pkg holds word_t (signed 11-bit), DIR_L/R/U/D one-hot 4-bit constants and dir index enum.
REQ-033 Sub-module rr_pick: combinational 4-way rotating priority encoder (inputs request mask, last_grant, mode; outputs one-hot grant, valid).
REQ-034 All state in one clocked process in port_rr_arbiter.

Verification
REQ-035 rready=1111 constant, sink_ready=1, mode=0, data L=1,R=2,U=3,D=4 -> out_data sequence 1,2,3,4,1 on consecutive cycles; read pulses L,R,U,D,L.
REQ-036 Only rready[2]=1 held high, din_u=-5, sink_ready=1 -> read[2] pulses every second cycle, out_data=-5, out_src=0100, grant_cnt +1 per 2 cycles.
REQ-037 mode=1, rready=1010 constant, sink_ready=1 -> R granted when not in cooldown, D granted only in R's cooldown cycles.
REQ-038 sink_ready=0, rready=0001, din_l=7 -> one read[0] pulse, out_valid=1 held, no further reads; raise sink_ready -> next word accepted same cycle as consume.
REQ-039 rst pulsed while out_valid=1 and read pulse pending -> next cycle all outputs 0, first grant after release goes to L with rready=1111.
REQ-040 256 accepts -> grant_cnt returns to 0.

Source files
------------

// File: rtl/tis_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tis_pkg: shared word type and port direction encodings            |
// | Rev 1.0 - initial release                                          |
// +------------------------------------------------------------------+
package tis_pkg;

  typedef logic signed [10:0] word_t;

  localparam logic [3:0] DIR_L = 4'b0001;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_D = 4'b1000;

  typedef enum logic [1:0] {
    IDX_L = 2'd0,
    IDX_R = 2'd1,
    IDX_U = 2'd2,
    IDX_D = 2'd3
  } dir_idx_e;

  function automatic dir_idx_e onehot_to_idx(input logic [3:0] oh);
    case (oh)
      DIR_L:   return IDX_L;
      DIR_R:   return IDX_R;
      DIR_U:   return IDX_U;
      default: return IDX_D;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick: 4-way rotating / fixed priority encoder (combinational)  |
// | Rev 1.0 - initial release                                          |
// +------------------------------------------------------------------+
module rr_pick
  import tis_pkg::*;
(
  input  logic [3:0] req,
  input  dir_idx_e   last,
  input  logic       mode,
  output logic [3:0] grant,
  output logic       valid
);

  // Round-robin starts one past the last winner; fixed mode always starts at L.
  always_comb begin
    logic [1:0] w_pos;
    w_pos = 2'd0;
    grant = 4'b0000;
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_pos = mode ? 2'(i) : 2'(last) + 2'(i + 1);
      if (!valid && req[w_pos]) begin
        grant[w_pos] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | port_rr_arbiter: 4-port arbiter feeding a single-entry register   |
// | Rev 1.0 - initial release                                          |
// +------------------------------------------------------------------+
module port_rr_arbiter
  import tis_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rready,
  input  logic signed [10:0] din_l,
  input  logic signed [10:0] din_r,
  input  logic signed [10:0] din_u,
  input  logic signed [10:0] din_d,
  input  logic              mode,
  input  logic              sink_ready,
  output logic [3:0]        read,
  output logic              out_valid,
  output logic signed [10:0] out_data,
  output logic [3:0]        out_src,
  output logic [7:0]        grant_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0] r_state;
  word_t      r_data;
  logic [3:0] r_src;
  logic [3:0] r_read;
  logic [7:0] r_cnt;
  dir_idx_e   r_last;

  logic       w_consume;
  logic       w_accept;
  logic [3:0] w_elig;
  logic [3:0] w_grant;
  logic       w_pick_valid;
  word_t      w_din;

  // The last read pulse doubles as the cooldown mask: the requester's rready
  // still shows the old word during the cycle its read pulse is visible.
  assign w_elig    = rready & ~r_read;
  assign w_consume = (r_state == ST_FULL) && sink_ready;
  assign w_accept  = ((r_state == ST_EMPTY) || w_consume) && w_pick_valid;

  rr_pick u_pick (
    .req   (w_elig),
    .last  (r_last),
    .mode  (mode),
    .grant (w_grant),
    .valid (w_pick_valid)
  );

  always_comb begin
    case (w_grant)
      DIR_L:   w_din = din_l;
      DIR_R:   w_din = din_r;
      DIR_U:   w_din = din_u;
      DIR_D:   w_din = din_d;
      default: w_din = din_l;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_src   <= '0;
      r_read  <= '0;
      r_cnt   <= '0;
      r_last  <= IDX_D;
    end else begin
      r_read <= '0;
      if (w_accept) begin
        r_state <= ST_FULL;
        r_data  <= w_din;
        r_src   <= w_grant;
        r_read  <= w_grant;
        r_last  <= onehot_to_idx(w_grant);
        r_cnt   <= r_cnt + 8'd1;
      end else if (w_consume) begin
        r_state <= ST_EMPTY;
        r_src   <= '0;
      end
    end
  end

  assign read      = r_read;
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign grant_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_port_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_port_rr_arbiter: directed stimulus, per-cycle reference model  |
// | Rev 1.0 - initial release                                          |
// +------------------------------------------------------------------+
module tb_port_rr_arbiter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         rready = 4'b0000;
  logic signed [10:0] din_l = '0, din_r = '0, din_u = '0, din_d = '0;
  logic               mode = 1'b0;
  logic               sink_ready = 1'b0;
  logic [3:0]         read;
  logic               out_valid;
  logic signed [10:0] out_data;
  logic [3:0]         out_src;
  logic [7:0]         grant_cnt;

  int n_pass  = 0;
  int n_total = 0;

  port_rr_arbiter dut (
    .clk(clk), .rst(rst), .rready(rready),
    .din_l(din_l), .din_r(din_r), .din_u(din_u), .din_d(din_d),
    .mode(mode), .sink_ready(sink_ready),
    .read(read), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: ports as integers 0..3, -1 meaning "none".
  int m_valid, m_data, m_src, m_read, m_cnt, m_last;

  function automatic int pick(input logic [3:0] rr, input int cool,
                              input int last, input logic md);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = md ? k : (last + 1 + k) % 4;
      if (rr[p] && p != cool) return p;
    end
    return -1;
  endfunction

  function automatic int din_of(input int p);
    case (p)
      0: return int'(din_l);
      1: return int'(din_r);
      2: return int'(din_u);
      default: return int'(din_d);
    endcase
  endfunction

  function automatic int onehot(input int p);
    return (p < 0) ? 0 : (1 << p);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = -1; m_read = -1; m_cnt = 0; m_last = 3;
    end else begin
      int g;
      bit cons;
      cons = (m_valid == 1) && sink_ready;
      g = -1;
      if (m_valid == 0 || cons) g = pick(rready, m_read, m_last, mode);
      m_read = g;
      if (g >= 0) begin
        m_valid = 1; m_data = din_of(g); m_src = g; m_last = g;
        m_cnt = (m_cnt + 1) % 256;
      end else if (cons) begin
        m_valid = 0; m_src = -1;
      end
    end
  end

  bit started = 0;
  always @(negedge clk) begin
    if (started && !rst) begin
      check("model_valid", int'(out_valid), m_valid);
      check("model_data",  int'(out_data),  m_data);
      check("model_src",   int'(out_src),   onehot(m_src));
      check("model_read",  int'(read),      onehot(m_read));
      check("model_cnt",   int'(grant_cnt), m_cnt);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed { logic [3:0] rr; logic sk; logic md; } vec_t;
  vec_t mix [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_data [5];
    int exp_read [5];
    exp_data = '{1, 2, 3, 4, 1};
    exp_read = '{1, 2, 4, 8, 1};

    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data),  0);
    check("rst_src",   int'(out_src),   0);
    check("rst_read",  int'(read),      0);
    check("rst_cnt",   int'(grant_cnt), 0);
    started = 1;

    // Round-robin over all four ports, one word per cycle.
    din_l = 11'sd1; din_r = 11'sd2; din_u = 11'sd3; din_d = 11'sd4;
    rready = 4'b1111; sink_ready = 1'b1; mode = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_data", int'(out_data), exp_data[i]);
      check("rr_read", int'(read),     exp_read[i]);
    end

    // Single port: every second cycle, negative data.
    do_reset();
    rready = 4'b0100; din_u = -11'sd5;
    repeat (7) @(negedge clk);
    check("single_read7", int'(read), 4'b0100);
    @(negedge clk);
    check("single_read8", int'(read), 0);
    check("single_cnt",   int'(grant_cnt), 4);
    check("single_data",  int'(out_data), -5);

    // Fixed priority: R, then D during R's cooldown.
    do_reset();
    mode = 1'b1; rready = 4'b1010; din_r = 11'sd20; din_d = -11'sd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fixed_read", int'(read), (i % 2 == 0) ? 2 : 8);
    end

    // Stalled sink: one read, then hold; release accepts next word at once.
    do_reset();
    mode = 1'b0; sink_ready = 1'b0; rready = 4'b0001; din_l = 11'sd7;
    @(negedge clk);
    check("stall_read1", int'(read), 1);
    repeat (3) @(negedge clk);
    check("stall_read", int'(read), 0);
    check("stall_valid", int'(out_valid), 1);
    check("stall_data", int'(out_data), 7);
    sink_ready = 1'b1; din_l = 11'sd8;
    @(negedge clk);
    check("release_read", int'(read), 1);
    check("release_data", int'(out_data), 8);
    check("release_valid", int'(out_valid), 1);

    // Reset while a word is held and a read is about to pulse.
    do_reset();
    rready = 4'b1111; din_l = 11'sd11; din_r = 11'sd22;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_read",  int'(read), 0);
    check("midrst_data",  int'(out_data), 0);
    check("midrst_cnt",   int'(grant_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_read", int'(read), 1);
    check("postrst_data", int'(out_data), 11);

    // Mixed directed vectors, checked by the model each cycle.
    mix = '{ '{4'b1111,1'b1,1'b1}, '{4'b1111,1'b1,1'b1}, '{4'b0110,1'b0,1'b0},
             '{4'b0110,1'b1,1'b0}, '{4'b0000,1'b1,1'b0}, '{4'b1001,1'b1,1'b0},
             '{4'b1001,1'b1,1'b1}, '{4'b1100,1'b0,1'b1}, '{4'b1100,1'b1,1'b0},
             '{4'b0011,1'b1,1'b0}, '{4'b1111,1'b1,1'b0}, '{4'b1111,1'b1,1'b1} };
    din_u = 11'sd1023; din_d = -11'sd1024;
    foreach (mix[i]) begin
      rready = mix[i].rr; sink_ready = mix[i].sk; mode = mix[i].md;
      @(negedge clk);
    end

    // Counter wrap: alternating L/U gives one accept per cycle.
    do_reset();
    mode = 1'b0; sink_ready = 1'b1; rready = 4'b0101;
    repeat (255) @(negedge clk);
    check("cnt_255", int'(grant_cnt), 255);
    @(negedge clk);
    check("cnt_wrap", int'(grant_cnt), 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
